// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order {pc, inst} queue toward decode, redirect flush. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]   inst_mem_q [QUEUE_DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   hold_pc_q, hold_inst_q;
    state_t        state_q, state_d;

    logic [31:0]   redirect_addr;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          push;
    logic          pop;

    assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;

    // Every issued request owns a queue slot until its response is popped or dropped,
    // so a response always finds room.
    assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};
    assign imem_req_valid = !reset && !halt && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem_q[head_q]   : hold_pc_q;
    assign out_inst  = out_valid ? inst_mem_q[head_q] : hold_inst_q;

    assign push = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        state_d       = state_q;
        if (redirect_valid) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            fetch_pc_d    = redirect_addr;
            resp_pc_d     = redirect_addr;
            outstanding_d = outstanding_q - CW'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - CW'(imem_resp_valid);
            state_d       = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                tail_d    = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d       = count_q + CW'(push) - CW'(pop);
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if ((state_q == ST_FLUSH) && (drop_cnt_d == '0)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            state_q       <= ST_RUN;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            state_q       <= state_d;
        end
    end

    // Queue storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= resp_pc_q;
            inst_mem_q[tail_q] <= imem_resp_data;
        end
    end

    // Shadow of the displayed head so the outputs hold while the queue is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else if (out_valid) begin
            hold_pc_q   <= out_pc;
            hold_inst_q <= out_inst;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        resp_drop;
    logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;

    assign resp_drop = imem_resp_valid && !push;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_flushed_q <= perf_flushed_q + (redirect_valid ? 32'(count_q) : 32'd0)
                              + 32'(resp_drop);
            perf_stall_q   <= perf_stall_q + 32'(out_ready && !out_valid);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: vector table for stream/backpressure/reset,
// hand sequences for redirect and halt corner cases, behavioural imem with configurable latency.
module tb_fetch_queue_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'd0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    bit inv_en   = 1'b0;

    fetch_queue_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: in-order responses mem_lat cycles after acceptance, data = addr ^ K.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    always @(negedge clk) begin
        imem_resp_valid <= 1'b0;
        if (reset) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mq[0].addr ^ K;
                void'(mq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + mem_lat});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Credit invariants on the internal counters, every cycle once reset has been applied.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_outstanding_le_depth", {31'b0, int'(dut.outstanding_q) <= 4}, 32'd1);
            chk("inv_drop_cnt_le_depth", {31'b0, int'(dut.drop_cnt_q) <= 4}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input string nm, input int rv, input logic [31:0] a);
        chk({nm, "_req_valid"}, {31'b0, imem_req_valid}, 32'(rv));
        if (rv != 0) chk({nm, "_req_addr"}, imem_req_addr, a);
    endtask

    task automatic exp_out(input string nm, input int ov, input logic [31:0] pc, input logic [31:0] inst);
        chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'(ov));
        chk({nm, "_out_pc"}, out_pc, pc);
        chk({nm, "_out_inst"}, out_inst, inst);
    endtask

    typedef struct {
        logic        chk_en;
        logic        rst;
        logic        rdy;
        logic        erv;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int c, input int r, input int y, input int v, input int a,
                       input int o, input int p, input logic [31:0] n);
        vec_t e;
        e.chk_en = (c != 0);
        e.rst    = (r != 0);
        e.rdy    = (y != 0);
        e.erv    = (v != 0);
        e.eaddr  = 32'(a);
        e.eov    = (o != 0);
        e.epc    = 32'(p);
        e.einst  = n;
        vecs.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;

        //  chk rst rdy  rv addr  ov pc  inst
        // Sequential stream from reset.
        add(0, 1, 1, 0, 0,  0, 0,  32'h0);
        add(1, 1, 1, 0, 0,  0, 0,  32'h0);
        add(1, 0, 1, 1, 0,  0, 0,  32'h0);
        add(1, 0, 1, 1, 4,  0, 0,  32'h0);
        add(1, 0, 1, 1, 8,  1, 0,  32'hA5A5_0000);
        add(1, 0, 1, 1, 12, 1, 4,  32'hA5A5_0004);
        add(1, 0, 1, 1, 16, 1, 8,  32'hA5A5_0008);
        add(1, 0, 1, 1, 20, 1, 12, 32'hA5A5_000C);
        // Reset mid-stream, then 10 cycles of backpressure and release.
        add(1, 1, 1, 0, 0,  1, 16, 32'hA5A5_0010);
        add(1, 1, 1, 0, 0,  0, 0,  32'h0);
        add(1, 0, 0, 1, 0,  0, 0,  32'h0);
        add(1, 0, 0, 1, 4,  0, 0,  32'h0);
        add(1, 0, 0, 1, 8,  1, 0,  32'hA5A5_0000);
        add(1, 0, 0, 1, 12, 1, 0,  32'hA5A5_0000);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 1, 0, 32'hA5A5_0000);
        add(1, 0, 1, 0, 0,  1, 0,  32'hA5A5_0000);
        add(1, 0, 1, 1, 16, 1, 4,  32'hA5A5_0004);
        add(1, 0, 1, 1, 20, 1, 8,  32'hA5A5_0008);
        add(1, 0, 1, 1, 24, 1, 12, 32'hA5A5_000C);
        add(1, 0, 1, 1, 28, 1, 16, 32'hA5A5_0010);
        // Fill the queue, then reset with it full.
        add(1, 1, 1, 0, 0,  1, 20, 32'hA5A5_0014);
        add(1, 1, 1, 0, 0,  0, 0,  32'h0);
        add(1, 0, 0, 1, 0,  0, 0,  32'h0);
        add(1, 0, 0, 1, 4,  0, 0,  32'h0);
        add(1, 0, 0, 1, 8,  1, 0,  32'hA5A5_0000);
        add(1, 0, 0, 1, 12, 1, 0,  32'hA5A5_0000);
        add(1, 0, 0, 0, 0,  1, 0,  32'hA5A5_0000);
        add(1, 0, 0, 0, 0,  1, 0,  32'hA5A5_0000);
        add(1, 1, 1, 0, 0,  1, 0,  32'hA5A5_0000);
        add(1, 1, 1, 0, 0,  0, 0,  32'h0);
        add(1, 0, 0, 1, 0,  0, 0,  32'h0);

        step();
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            out_ready = vecs[i].rdy;
            #1;
            $display("vec %0d rst=%0b rdy=%0b req_valid=%0b addr=%h out_valid=%0b pc=%h inst=%h",
                     i, reset, out_ready, imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst);
            if (vecs[i].chk_en) begin
                chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].erv});
                if (vecs[i].erv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
                chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
                chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].einst);
            end
            if (i == 1) inv_en = 1'b1;
            step();
        end

        // Redirect with in-flight responses, 3-cycle memory.
        mem_lat = 3; reset = 1'b1; out_ready = 1'b1;
        step(); step();
        reset = 1'b0; #1;
        $display("seq redirect_inflight start");
        exp_req("rd_c0", 1, 32'h0);
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
        exp_req("rd_c3", 0, 32'h0);
        exp_out("rd_c3", 0, 32'h0, 32'h0);
        step();
        redirect_valid = 1'b0; #1;
        exp_req("rd_c4", 1, 32'h100);
        exp_out("rd_c4", 0, 32'h0, 32'h0);
        chk("rd_c4_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        step(); #1;
        exp_req("rd_c5", 1, 32'h104);
        chk("rd_c5_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        exp_out("rd_c5", 0, 32'h0, 32'h0);
        step(); #1;
        exp_req("rd_c6", 1, 32'h108);
        chk("rd_c6_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
        exp_out("rd_c6", 0, 32'h0, 32'h0);
        step(); #1;
        exp_req("rd_c7", 1, 32'h10C);
        exp_out("rd_c7", 0, 32'h0, 32'h0);
        step(); #1;
        exp_out("rd_c8", 1, 32'h100, 32'hA5A5_0100);
        step(); #1;
        exp_out("rd_c9", 1, 32'h104, 32'hA5A5_0104);

        // Redirect coinciding with a response and a pop, 1-cycle memory.
        mem_lat = 1; reset = 1'b1;
        step(); step();
        reset = 1'b0; #1;
        $display("seq redirect_resp_pop start");
        step(); step(); #1;
        exp_out("rp_c2", 1, 32'h0, 32'hA5A5_0000);
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        exp_req("rp_c3", 0, 32'h0);
        exp_out("rp_c3", 1, 32'h4, 32'hA5A5_0004);
        step();
        redirect_valid = 1'b0; #1;
        exp_out("rp_c4", 0, 32'h4, 32'hA5A5_0004);
        exp_req("rp_c4", 1, 32'h200);
        step(); #1;
        exp_out("rp_c5", 0, 32'h4, 32'hA5A5_0004);
        exp_req("rp_c5", 1, 32'h204);
        step(); #1;
        exp_out("rp_c6", 1, 32'h200, 32'hA5A5_0200);

        // Halt with two responses outstanding, then redirect while halted, 3-cycle memory.
        mem_lat = 3; reset = 1'b1;
        step(); step();
        reset = 1'b0; #1;
        $display("seq halt start");
        exp_req("ht_c0", 1, 32'h0);
        step(); #1;
        exp_req("ht_c1", 1, 32'h4);
        step();
        halt = 1'b1; #1;
        exp_req("ht_c2", 0, 32'h0);
        step(); #1;
        exp_req("ht_c3", 0, 32'h0);
        exp_out("ht_c3", 0, 32'h0, 32'h0);
        step(); #1;
        exp_req("ht_c4", 0, 32'h0);
        exp_out("ht_c4", 1, 32'h0, 32'hA5A5_0000);
        step(); #1;
        exp_out("ht_c5", 1, 32'h4, 32'hA5A5_0004);
        step(); #1;
        exp_out("ht_c6", 0, 32'h4, 32'hA5A5_0004);
        exp_req("ht_c6", 0, 32'h0);
        step();
        halt = 1'b0; imem_req_ready = 1'b0; #1;
        exp_req("ht_c7", 1, 32'h8);
        step();
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; imem_req_ready = 1'b1; #1;
        exp_req("ht_c8", 0, 32'h0);
        step();
        redirect_valid = 1'b0; #1;
        exp_req("ht_c9", 0, 32'h0);
        step();
        halt = 1'b0; #1;
        exp_req("ht_c10", 1, 32'h300);
        step();

        inv_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction fetch stage directly upstream of the CPU decode/execute datapath.
- Generates sequential PCs and issues word reads to instruction memory over a request/response interface.
- Buffers returned instructions in an in-order queue and hands {pc, inst} to decode with a valid/ready handshake.
- Handles redirects from taken branch/jal/jalr by flushing the queue and discarding in-flight responses.

Parameters:
- QUEUE_DEPTH, 4, number of queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  input  32  instruction word.
- out_valid  output  1  queue head valid toward decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  PC of head entry.
- out_inst  output  32  instruction of head entry.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- halt  input  1  stop issuing new requests (driven from is_halted).

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - fetch_pc and resp_pc <= RESET_PC.
  - Queue empty; outstanding <= 0; drop_cnt <= 0.
  - Outputs after reset: imem_req_valid=0, out_valid=0, out_pc=0, out_inst=0.
  - Reset mid-operation discards everything; responses arriving after reset for pre-reset requests are not protected (the memory is reset together with this block).
- Issue:
  - imem_req_valid = !reset && !halt && !redirect_valid && (count + outstanding - drop_cnt) < QUEUE_DEPTH.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- Response: each imem_resp_valid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {resp_pc, imem_resp_data} is pushed at the tail and resp_pc += 4.
  - A response is never lost for lack of space; the credit rule guarantees this.
- Dequeue:
  - out_valid = (count != 0); out_pc/out_inst show the head combinationally from registered storage.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged; push into a full queue with a simultaneous pop is legal.
  - When empty, out_pc/out_inst hold their last value (0 after reset).
- Redirect (priority over push, pop and issue in the same cycle):
  - Queue cleared.
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_cnt <= outstanding after this cycle's response, i.e. `outstanding - imem_resp_valid`; a response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle; fetch resumes the next cycle.
- Latency: with a 1-cycle memory, a redirect issued in cycle N gives a request in N+1, response in N+2, and out_valid in N+3.
- Halt: blocks new requests only. Outstanding responses still fill the queue and decode can still drain it. Redirect while halted updates the PCs but does not issue.
- Counters: `count` is 0..QUEUE_DEPTH; outstanding and drop_cnt are log2(QUEUE_DEPTH)+1 bits wide. Both `outstanding` and `drop_cnt` are ≤ QUEUE_DEPTH at all times; the bench asserts this.
- State machine: 2 states.
  - RUN: normal operation.
  - FLUSH: entered on redirect when drop_cnt_next > 0; returns to RUN when drop_cnt reaches 0.
  - Issue is allowed in both states; FLUSH only marks that responses are being discarded. The state is observable through the perf/debug path only.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] (instructions popped to decode), perf_flushed[31:0] (queue entries cleared plus responses dropped) and perf_stall[31:0] (cycles with out_ready=1 && out_valid=0 && !reset). All are reset to 0 and wrap on overflow.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Sequential stream: reset, 1-cycle memory returning data = addr ^ 32'hA5A5_0000, out_ready=1 → out_pc = 0, 4, 8, 12… with matching out_inst, one per cycle after a 2-cycle startup.
- Backpressure: out_ready=0 for 10 cycles with QUEUE_DEPTH=4 → exactly 4 requests accepted, count=4, imem_req_valid=0. Raising out_ready → pops resume in order from pc 0.
- Redirect with in-flight responses: 3-cycle memory, 3 outstanding, redirect_pc=32'h0000_0103 → next out_pc=32'h100, no stale instruction ever reaches decode, drop_cnt returns to 0.
- Redirect in the same cycle as a response and a pop → response dropped, queue empty next cycle, no pop counted.
- Halt: halt=1 with 2 outstanding → no new requests; both responses enqueued and drained; halt=0 → fetch resumes at the next sequential PC.
- Reset mid-stream: reset asserted with a full queue → next cycle out_valid=0, imem_req_valid=0; after release the first request address is RESET_PC.
